// File: rtl/sincpde_div_seq_if.sv
// Request/result bundle between the DFS core and the sincpde divider.
interface sincpde_div_seq_if #(
    parameter int unsigned NW = 48,
    parameter int unsigned QW = 18
);
    logic                 sync_in;
    logic signed [NW-1:0] N;
    logic signed [NW-1:0] D;
    logic                 sync_out;
    logic signed [QW-1:0] Q;
    logic                 busy;
    logic                 overrun;

    modport master (
        output sync_in, N, D,
        input  sync_out, Q, busy, overrun
    );

    modport slave (
        input  sync_in, N, D,
        output sync_out, Q, busy, overrun
    );
endinterface

// File: rtl/sincpde_div_seq.sv
// Fixed-latency signed restoring divider with saturated QW-bit quotient.
module sincpde_div_seq #(
    parameter int unsigned NW = 48,
    parameter int unsigned QW = 18
) (
    input  logic            clk,
    input  logic            rst,
    sincpde_div_seq_if.slave bus
);
    localparam int unsigned CW = $clog2(QW);
    localparam int unsigned WW = NW + QW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [QW-1:0] QMAX = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] QMIN = {1'b1, {(QW-1){1'b0}}};

    logic [1:0]    state, state_nxt;
    logic          accept_c, overrun_set_c;

    logic [NW-1:0] n_reg, d_reg;
    logic          sgn, ovf;
    logic [NW-1:0] rem;
    logic [WW-1:0] dsh;
    logic [QW-1:0] qmag;
    logic [CW-1:0] cnt;

    logic [QW-1:0] q_r;
    logic          sync_out_r, busy_r, overrun_r;

    logic [NW-1:0] n_mag_c, d_mag_c;
    logic          ovf_c, trial_c;
    logic [QW-1:0] q_sat_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state and request acceptance; DONE may take a back-to-back request.
    always_comb begin
        state_nxt     = state;
        accept_c      = 1'b0;
        overrun_set_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.sync_in) begin
                    accept_c  = 1'b1;
                    state_nxt = S_PREP;
                end
            end
            S_PREP: begin
                overrun_set_c = bus.sync_in;
                state_nxt     = S_ITER;
            end
            S_ITER: begin
                overrun_set_c = bus.sync_in;
                if (cnt == '0) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (bus.sync_in) begin
                    accept_c  = 1'b1;
                    state_nxt = S_PREP;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Magnitudes, overflow detection, trial subtraction and final saturation.
    always_comb begin
        n_mag_c = n_reg[NW-1] ? NW'(-n_reg) : n_reg;
        d_mag_c = d_reg[NW-1] ? NW'(-d_reg) : d_reg;
        ovf_c   = (d_mag_c == '0) ||
                  ({{QW{1'b0}}, n_mag_c} >= {d_mag_c, {QW{1'b0}}});
        trial_c = ({{QW{1'b0}}, rem} >= dsh);
        if (ovf)
            q_sat_c = sgn ? QMIN : QMAX;
        else if (!sgn)
            q_sat_c = qmag[QW-1] ? QMAX : qmag;
        else
            q_sat_c = (qmag > QMIN) ? QMIN : QW'(-qmag);
    end

    // Operand capture and shift-subtract datapath, one quotient bit per ITER cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_reg <= '0;
            d_reg <= '0;
            sgn   <= 1'b0;
            ovf   <= 1'b0;
            rem   <= '0;
            dsh   <= '0;
            qmag  <= '0;
            cnt   <= '0;
        end else begin
            if (accept_c) begin
                n_reg <= bus.N;
                d_reg <= bus.D;
                sgn   <= bus.N[NW-1] ^ bus.D[NW-1];
            end
            if (state == S_PREP) begin
                ovf  <= ovf_c;
                rem  <= n_mag_c;
                dsh  <= {1'b0, d_mag_c, {(QW-1){1'b0}}};
                qmag <= '0;
                cnt  <= CW'(QW - 1);
                // Divide by zero saturates on the numerator sign alone.
                if (d_mag_c == '0) sgn <= n_reg[NW-1];
            end
            if (state == S_ITER) begin
                if (trial_c) rem <= rem - NW'(dsh);
                qmag <= {qmag[QW-2:0], trial_c};
                dsh  <= dsh >> 1;
                cnt  <= cnt - CW'(1);
            end
        end
    end

    // Registered outputs: result/strobe on leaving DONE, busy tracks next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r        <= '0;
            sync_out_r <= 1'b0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            sync_out_r <= (state == S_DONE);
            if (state == S_DONE) q_r <= q_sat_c;
            busy_r <= (state_nxt != S_IDLE);
            if (overrun_set_c) overrun_r <= 1'b1;
        end
    end

    assign bus.Q        = q_r;
    assign bus.sync_out = sync_out_r;
    assign bus.busy     = busy_r;
    assign bus.overrun  = overrun_r;
endmodule

// File: tb/tb_sincpde_div_seq.sv
// Scoreboard bench for sincpde_div_seq: expected quotients queued at issue, checked on sync_out.
module tb_sincpde_div_seq;
    localparam int unsigned NW  = 48;
    localparam int unsigned QW  = 18;
    localparam int          LAT = 21;

    typedef struct {
        longint q;
        longint due;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    longint t_issue = 0;
    int     n_chk = 0;
    int     n_err = 0;
    exp_t   sb[$];

    sincpde_div_seq_if #(.NW(NW), .QW(QW)) bus ();

    sincpde_div_seq #(.NW(NW), .QW(QW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: C-style truncating divide, then clamp to the QW-bit signed range.
    function automatic longint model(input longint n, input longint d);
        longint q;
        if (d == 0) return (n < 0) ? -131072 : 131071;
        q = n / d;
        if (q > 131071)  q = 131071;
        if (q < -131072) q = -131072;
        return q;
    endfunction

    // Result monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst && bus.sync_out) begin
            if (sb.size() == 0) begin
                check("spurious_sync_out", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("q", longint'($signed(bus.Q)), e.q);
                check("latency", cyc, e.due);
            end
        end
    end

    task automatic issue(input longint n, input longint d);
        exp_t e;
        bus.N       = NW'(n);
        bus.D       = NW'(d);
        bus.sync_in = 1'b1;
        t_issue     = cyc;
        e.q         = model(n, d);
        e.due       = cyc + LAT;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.sync_in = 1'b0;
    endtask

    // Advance until cycle t_issue+k (bounded by construction).
    task automatic gap(input int k);
        while (cyc < t_issue + k) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [63:0] r;
        longint      rn, rd;

        bus.sync_in = 1'b0;
        bus.N       = '0;
        bus.D       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", longint'($signed(bus.Q)), 0);
        check("rst_sync_out", longint'(bus.sync_out), 0);
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_overrun", longint'(bus.overrun), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Signs; each next request lands in the previous sync_out cycle.
        issue(100, 7);
        check("busy_t1", longint'(bus.busy), 1);
        gap(LAT);
        issue(-100, 7);   gap(LAT);
        issue(100, -7);   gap(LAT);
        issue(-100, -7);  gap(LAT);

        // Saturation and boundaries.
        issue(1000000, 3);        gap(LAT);
        issue(-131072 * 5, 5);    gap(LAT);
        issue(131072 * 5, 5);     gap(LAT);
        issue(-(64'sd1 <<< 47), 1); gap(LAT);
        issue(131071 * 3, 3);     gap(LAT);
        issue(0, -9);             gap(LAT);

        // Divide by zero.
        issue(-5, 0);  gap(LAT);
        issue(0, 0);   gap(LAT);

        // Back-to-back.
        issue(100, 7); gap(LAT);
        issue(-9, 2);  gap(LAT);

        // Random operands.
        for (int i = 0; i < 6; i++) begin
            r  = {$urandom, $urandom};
            rn = longint'($signed(r[47:0])) >>> (i * 5);
            rd = longint'($urandom_range(1, 5000)) - 2500;
            if (i % 2 == 1) rd = rd * 64'sd1000003;
            issue(rn, rd);
            gap(LAT);
        end
        gap(LAT + 2);
        check("overrun_clean", longint'(bus.overrun), 0);
        check("sb_empty_1", longint'(sb.size()), 0);

        // Overrun: second request during ITER is dropped.
        issue(-1234567, 89);
        gap(5);
        bus.N       = NW'(64'sd999);
        bus.D       = NW'(64'sd1);
        bus.sync_in = 1'b1;
        @(posedge clk); #1;
        bus.sync_in = 1'b0;
        @(posedge clk); #1;
        check("overrun_set", longint'(bus.overrun), 1);
        gap(LAT + 5);
        check("sb_empty_2", longint'(sb.size()), 0);
        check("overrun_sticky", longint'(bus.overrun), 1);

        // Reset mid-operation aborts the result.
        issue(5000, 3);
        gap(10);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        gap(LAT + 2);
        check("abort_q", longint'($signed(bus.Q)), 0);
        check("abort_overrun", longint'(bus.overrun), 0);
        check("abort_busy", longint'(bus.busy), 0);
        issue(-77777, 11);
        gap(LAT + 1);

        for (int k = 0; k < 50 && sb.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check("sb_drain", longint'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
